// File: rtl/uncache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uncache_arbiter
// Purpose  : Shares one AXI bridge port between the instruction-side and the
//            data-side uncached access paths. One transfer is in flight at a
//            time; the granted side's command is latched and held on the
//            bridge until the bridge pulses axi_refresh, then the bridge read
//            data is returned with a one-cycle done pulse.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            i_req/i_wen/i_addr/i_wdata - instruction-side command
//            i_rdata/i_done/i_stall   - instruction-side response
//            d_*                      - same set for the data side
//            axi_en/axi_wsel/axi_addr/axi_wdata - command to the bridge
//            axi_refresh/axi_rdata    - completion pulse and data from bridge
// Params   : FIXED_PRIO - 1: data side wins every tie; 0: round-robin tie
// Revision : 1.0 - initial release
// ============================================================================
module uncache_arbiter #(
    parameter int FIXED_PRIO = 1
) (
    input  logic        clk,
    input  logic        rst,
    // instruction side
    input  logic        i_req,
    input  logic [3:0]  i_wen,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] i_rdata,
    output logic        i_done,
    output logic        i_stall,
    // data side
    input  logic        d_req,
    input  logic [3:0]  d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    // shared bridge
    output logic        axi_en,
    output logic [3:0]  axi_wsel,
    output logic [31:0] axi_addr,
    output logic [31:0] axi_wdata,
    input  logic        axi_refresh,
    input  logic [31:0] axi_rdata
);

    localparam logic c_FIXED_PRIO_EN = (FIXED_PRIO != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state,     w_state_nxt;
    logic        r_axi_en,    w_axi_en_nxt;
    logic [3:0]  r_axi_wsel,  w_axi_wsel_nxt;
    logic [31:0] r_axi_addr,  w_axi_addr_nxt;
    logic [31:0] r_axi_wdata, w_axi_wdata_nxt;
    logic [31:0] r_i_rdata,   w_i_rdata_nxt;
    logic [31:0] r_d_rdata,   w_d_rdata_nxt;
    logic        r_i_done,    w_i_done_nxt;
    logic        r_d_done,    w_d_done_nxt;
    // 1 when the data side was served last; resets to instruction so the
    // data side wins the first round-robin tie.
    logic        r_last_d,    w_last_d_nxt;
    logic        w_grant_d;

    // Data side is granted when it is alone, or on a tie when fixed priority
    // is enabled or the instruction side was served last.
    assign w_grant_d = d_req & (~i_req | c_FIXED_PRIO_EN | ~r_last_d);

    always_comb begin
        w_state_nxt     = r_state;
        w_axi_en_nxt    = r_axi_en;
        w_axi_wsel_nxt  = r_axi_wsel;
        w_axi_addr_nxt  = r_axi_addr;
        w_axi_wdata_nxt = r_axi_wdata;
        w_i_rdata_nxt   = r_i_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_i_done_nxt    = r_i_done;
        w_d_done_nxt    = r_d_done;
        w_last_d_nxt    = r_last_d;

        case (r_state)
            S_IDLE: begin
                if (i_req || d_req) begin
                    w_axi_en_nxt = 1'b1;
                    if (w_grant_d) begin
                        w_axi_wsel_nxt  = d_wen;
                        w_axi_addr_nxt  = d_addr;
                        w_axi_wdata_nxt = d_wdata;
                        w_last_d_nxt    = 1'b1;
                        w_state_nxt     = S_BUSY_D;
                    end else begin
                        w_axi_wsel_nxt  = i_wen;
                        w_axi_addr_nxt  = i_addr;
                        w_axi_wdata_nxt = i_wdata;
                        w_last_d_nxt    = 1'b0;
                        w_state_nxt     = S_BUSY_I;
                    end
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                // Requester inputs are not looked at here: the latched
                // command stays on the bridge until it completes.
                if (axi_refresh) begin
                    w_axi_en_nxt    = 1'b0;
                    w_axi_wsel_nxt  = 4'd0;
                    w_axi_addr_nxt  = 32'd0;
                    w_axi_wdata_nxt = 32'd0;
                    if (r_state == S_BUSY_I) begin
                        w_i_rdata_nxt = axi_rdata;
                        w_i_done_nxt  = 1'b1;
                    end else begin
                        w_d_rdata_nxt = axi_rdata;
                        w_d_done_nxt  = 1'b1;
                    end
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // One-cycle gap so the finished requester can drop its req
                // before the next arbitration.
                w_i_done_nxt = 1'b0;
                w_d_done_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_axi_en    <= 1'b0;
            r_axi_wsel  <= 4'd0;
            r_axi_addr  <= 32'd0;
            r_axi_wdata <= 32'd0;
            r_i_rdata   <= 32'd0;
            r_d_rdata   <= 32'd0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_last_d    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_axi_en    <= w_axi_en_nxt;
            r_axi_wsel  <= w_axi_wsel_nxt;
            r_axi_addr  <= w_axi_addr_nxt;
            r_axi_wdata <= w_axi_wdata_nxt;
            r_i_rdata   <= w_i_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_i_done    <= w_i_done_nxt;
            r_d_done    <= w_d_done_nxt;
            r_last_d    <= w_last_d_nxt;
        end
    end

    assign axi_en    = r_axi_en;
    assign axi_wsel  = r_axi_wsel;
    assign axi_addr  = r_axi_addr;
    assign axi_wdata = r_axi_wdata;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign i_done    = r_i_done;
    assign d_done    = r_d_done;

    // Stall is combinational so it drops in the very cycle done is seen.
    assign i_stall = ~rst & i_req & ~r_i_done;
    assign d_stall = ~rst & d_req & ~r_d_done;

endmodule
`default_nettype wire

// File: doc/uncache_arbiter.md
UNCACHE_ARBITER -- requirements
Module: uncache_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 1, meaning: 1 = data side always wins a tie; 0 = round-robin between sides.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_req  input  1  instruction-side uncached request; held high until i_done is seen.
REQ-005 i_wen  input  4  instruction-side byte write enables; 0 means read.
REQ-006 i_addr  input  32  instruction-side address.
REQ-007 i_wdata  input  32  instruction-side write data.
REQ-008 i_rdata  output  32  read data returned to the instruction side.
REQ-009 i_done  output  1  one-cycle completion pulse to the instruction side.
REQ-010 i_stall  output  1  stall request to the instruction side.
REQ-011 d_req, d_wen, d_addr, d_wdata, d_rdata, d_done, d_stall SHALL mirror REQ-004..REQ-010 for the data side, with identical widths.
REQ-012 axi_en  output  1  request to the shared AXI bridge.
REQ-013 axi_wsel  output  4  byte write select to the bridge.
REQ-014 axi_addr  output  32  address to the bridge.
REQ-015 axi_wdata  output  32  write data to the bridge.
REQ-016 axi_refresh  input  1  bridge completion pulse for the current transfer.
REQ-017 axi_rdata  input  32  bridge read data, valid while axi_refresh is high.

Function
REQ-018 The FSM SHALL have four states: IDLE, BUSY_I, BUSY_D and DONE.
REQ-019 In IDLE with exactly one req high, the block SHALL latch that side's wen/addr/wdata into axi_wsel/axi_addr/axi_wdata, set axi_en=1 and move to BUSY_I or BUSY_D on the same edge.
REQ-020 In IDLE with both req high and FIXED_PRIO=1, the block SHALL grant the data side.
REQ-021 In IDLE with both req high and FIXED_PRIO=0, the block SHALL grant the side not served last; the last-served bit resets to "instruction", so the data side wins the first tie after reset.
REQ-022 In BUSY_x, axi_en/axi_wsel/axi_addr/axi_wdata SHALL hold stable until axi_refresh=1; later changes on x_req/x_addr SHALL be ignored.
REQ-023 In BUSY_x with axi_refresh=1, the block SHALL on the same edge: clear axi_en, axi_wsel, axi_addr and axi_wdata to 0; capture axi_rdata into x_rdata; set x_done=1; move to DONE.
REQ-024 DONE SHALL last exactly one cycle, clear both done outputs and return to IDLE; no grant is made in DONE.
REQ-025 x_rdata SHALL hold its value until the next completion on the same side; writes also update x_rdata with the bridge value.
REQ-026 x_stall SHALL equal x_req & ~x_done, combinationally, and SHALL be forced to 0 while rst=1.
REQ-027 Latency: req high in IDLE at cycle 0 gives axi_en=1 in cycle 1; refresh in cycle k gives x_done=1 in cycle k+1; the earliest next grant is at the end of cycle k+2.
REQ-028 axi_refresh in IDLE or DONE SHALL be ignored, with no state or output change.
REQ-029 At most one side's done SHALL be high in any cycle; the non-granted side's stall SHALL stay high throughout.

Reset
REQ-030 On rst=1, the block SHALL enter IDLE and set axi_en=0, axi_wsel=0, axi_addr=0, axi_wdata=0, i_done=d_done=0, i_rdata=d_rdata=0 and last-served=instruction.
REQ-031 rst during BUSY_x or DONE SHALL abort the transfer with no done pulse; the bridge is reset by the same rst.

Verification
REQ-032 Single data read: d_req=1, d_wen=0, d_addr=0xBFAF_F000; refresh in cycle 4 with axi_rdata=0x1234_5678 -> axi_en high in cycles 1-4, d_done=1 and d_rdata=0x1234_5678 in cycle 5, d_stall=0 in cycle 5.
REQ-033 Tie with FIXED_PRIO=1: i_req=d_req=1 -> data served first, then instruction granted at the end of the cycle after d_done; i_stall stays high until i_done.
REQ-034 Round-robin with FIXED_PRIO=0: both sides continuously requesting for four transfers -> grant order D, I, D, I.
REQ-035 Data write: d_wen=4'b0011, d_wdata=0xAABB_CCDD -> axi_wsel=0011 and axi_wdata=0xAABB_CCDD held stable until refresh, then cleared to 0.
REQ-036 Spurious refresh in IDLE and rst asserted in BUSY_I -> no done pulse, all outputs return to their reset values, and the next request completes normally.
